board_win_scanner: RTL and testbench

- Read-side companion to the 8x8 game board. The board is written one cell at a time through row_counter/clm_counter/update/fill_erase.
- This block snapshots the board on request and sequentially sweeps it for a straight run of RUN_LEN filled cells (horizontal, vertical, diagonal, anti-diagonal).
- It reports the first run found: start cell and direction. The game controller starts a scan after each move and waits on done.

---
 rtl/board_pkg.sv | 44 ++++
 rtl/board_win_scanner_if.sv | 45 ++++
 rtl/run_matcher.sv | 45 ++++
 rtl/board_win_scanner.sv | 116 +++++++++++
 tb/tb_board_win_scanner.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared types and the grid-stepping helper for the board win scanner.
package board_pkg;

    localparam int unsigned BOARD_N = 8;

    typedef logic [2:0] coord_t;
    typedef logic [BOARD_N-1:0][BOARD_N-1:0] board_t;

    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_t;

    typedef enum logic [1:0] {StIdle, StScan, StFin} state_t;

    typedef struct packed {
        logic   oob;
        coord_t row;
        coord_t clm;
    } step_t;

    // One step along dir; a 4-bit intermediate exposes leaving the grid (incl. clm 0 -> -1).
    function automatic step_t step(coord_t row, coord_t clm, dir_t dir);
        logic [3:0] r;
        logic [3:0] c;
        step_t      s;
        r = {1'b0, row};
        c = {1'b0, clm};
        case (dir)
            DIR_H:   c = c + 4'd1;
            DIR_V:   r = r + 4'd1;
            DIR_D:   begin
                r = r + 4'd1;
                c = c + 4'd1;
            end
            default: begin
                r = r + 4'd1;
                c = c - 4'd1;
            end
        endcase
        s.oob = r[3] | c[3];
        s.row = r[2:0];
        s.clm = c[2:0];
        return s;
    endfunction

endpackage

// File: rtl/board_win_scanner_if.sv
// Controller <-> scanner bundle. win_mask exists only when WIN_MASK_EN is defined.
interface board_win_scanner_if;
    import board_pkg::*;

    board_t      board;
    logic        start;
    logic        busy;
    logic        done;
    logic        win;
    coord_t      win_row;
    coord_t      win_clm;
    dir_t        win_dir;
`ifdef WIN_MASK_EN
    logic [63:0] win_mask;
`endif

    modport master (
        output board,
        output start,
`ifdef WIN_MASK_EN
        input  win_mask,
`endif
        input  busy,
        input  done,
        input  win,
        input  win_row,
        input  win_clm,
        input  win_dir
    );

    modport slave (
        input  board,
        input  start,
`ifdef WIN_MASK_EN
        output win_mask,
`endif
        output busy,
        output done,
        output win,
        output win_row,
        output win_clm,
        output win_dir
    );

endinterface

// File: rtl/run_matcher.sv
// Combinational check of one candidate run; the cell mask output exists under WIN_MASK_EN.
module run_matcher
    import board_pkg::*;
#(
    parameter int unsigned RUN_LEN = 5
) (
    input  board_t      snap,
    input  coord_t      row,
    input  coord_t      clm,
    input  dir_t        dir,
`ifdef WIN_MASK_EN
    output logic [63:0] mask,
`endif
    output logic        match
);

    coord_t r;
    coord_t c;
    logic   oob;
    step_t  s;

    always_comb begin
        match = 1'b1;
        oob   = 1'b0;
        r     = row;
        c     = clm;
        s     = '0;
`ifdef WIN_MASK_EN
        mask  = '0;
`endif
        for (int unsigned k = 0; k < RUN_LEN; k++) begin
            if (!snap[r][c]) match = 1'b0;
`ifdef WIN_MASK_EN
            mask[{r, c}] = 1'b1;
`endif
            s = step(r, c, dir);
            // Leaving the grid only matters if another cell is still needed.
            if (k != RUN_LEN - 1) oob = oob | s.oob;
            r = s.row;
            c = s.clm;
        end
        match = match & ~oob;
    end

endmodule

// File: rtl/board_win_scanner.sv
// Snapshots the board on start and sweeps all 256 candidates for a RUN_LEN run.
// Optional WIN_MASK_EN adds the win_mask output with the cells of the found run.
module board_win_scanner
    import board_pkg::*;
#(
    parameter int unsigned RUN_LEN = 5
) (
    input logic                clk,
    input logic                rst,
    board_win_scanner_if.slave bus
);

    state_t state_q, state_d;
    board_t snap_q;
    // Candidate index {dir, row, clm}, clm innermost.
    logic [7:0] idx_q;
    logic       win_q;
    coord_t     win_row_q;
    coord_t     win_clm_q;
    dir_t       win_dir_q;

    coord_t cur_row;
    coord_t cur_clm;
    dir_t   cur_dir;
    logic   match;
    logic   last;
    logic   start_acc;

    assign cur_dir   = dir_t'(idx_q[7:6]);
    assign cur_row   = idx_q[5:3];
    assign cur_clm   = idx_q[2:0];
    assign last      = &idx_q;
    assign start_acc = (state_q == StIdle) && bus.start;

`ifdef WIN_MASK_EN
    logic [63:0] cand_mask;
    logic [63:0] win_mask_q;
`endif

    run_matcher #(
        .RUN_LEN(RUN_LEN)
    ) u_matcher (
        .snap (snap_q),
        .row  (cur_row),
        .clm  (cur_clm),
        .dir  (cur_dir),
`ifdef WIN_MASK_EN
        .mask (cand_mask),
`endif
        .match(match)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StScan;
            StScan:  if (match || last) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q == StScan);
        bus.done    = (state_q == StFin);
        bus.win     = win_q;
        bus.win_row = win_row_q;
        bus.win_clm = win_clm_q;
        bus.win_dir = win_dir_q;
`ifdef WIN_MASK_EN
        bus.win_mask = win_mask_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q    <= '0;
            idx_q     <= '0;
            win_q     <= 1'b0;
            win_row_q <= '0;
            win_clm_q <= '0;
            win_dir_q <= DIR_H;
`ifdef WIN_MASK_EN
            win_mask_q <= '0;
`endif
        end else if (start_acc) begin
            snap_q    <= bus.board;
            idx_q     <= '0;
            win_q     <= 1'b0;
            win_row_q <= '0;
            win_clm_q <= '0;
            win_dir_q <= DIR_H;
`ifdef WIN_MASK_EN
            win_mask_q <= '0;
`endif
        end else if (state_q == StScan) begin
            if (match) begin
                win_q     <= 1'b1;
                win_row_q <= cur_row;
                win_clm_q <= cur_clm;
                win_dir_q <= cur_dir;
`ifdef WIN_MASK_EN
                win_mask_q <= cand_mask;
`endif
            end else begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_board_win_scanner.sv
// Scoreboard bench for board_win_scanner: stimulus pushes expectations, monitor checks on done.
module tb_board_win_scanner;
    import board_pkg::*;

    typedef struct {
        bit          win;
        int          row;
        int          clm;
        int          dir;
        logic [63:0] mask;
        time         t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    board_win_scanner_if bus();

    board_win_scanner #(
        .RUN_LEN(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(string pfx);
        chk({pfx, "_busy"}, 64'(bus.busy), 64'd0);
        chk({pfx, "_done"}, 64'(bus.done), 64'd0);
        chk({pfx, "_win"}, 64'(bus.win), 64'd0);
        chk({pfx, "_row"}, 64'(bus.win_row), 64'd0);
        chk({pfx, "_clm"}, 64'(bus.win_clm), 64'd0);
        chk({pfx, "_dir"}, 64'(bus.win_dir), 64'd0);
`ifdef WIN_MASK_EN
        chk({pfx, "_mask"}, bus.win_mask, 64'd0);
`endif
    endtask

    // Start edge E0 is the posedge after start is raised; done is sampled lat cycles later.
    task automatic issue(board_t b, bit w, int r, int c, int d, int lat, logic [63:0] m);
        exp_t e;
        @(negedge clk);
        bus.board = b;
        bus.start = 1'b1;
        @(posedge clk);
        e.win  = w;
        e.row  = r;
        e.clm  = c;
        e.dir  = d;
        e.mask = m;
        e.t    = $time + time'(lat * 10 + 5);
        q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string name);
        for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("done_time", 64'($time), 64'(e.t));
                    chk("busy_in_fin", 64'(bus.busy), 64'd0);
                    chk("win", 64'(bus.win), 64'(e.win));
                    chk("win_row", 64'(bus.win_row), 64'(e.row));
                    chk("win_clm", 64'(bus.win_clm), 64'(e.clm));
                    chk("win_dir", 64'(bus.win_dir), 64'(e.dir));
`ifdef WIN_MASK_EN
                    chk("win_mask", bus.win_mask, e.mask);
`endif
                end
            end
        end
    end

    initial begin : stimulus
        board_t b_empty, b_row, b_row4, b_vert, b_diag, b_anti;
        b_empty = '0;
        b_row   = '0;
        b_row[0][4:0] = 5'b11111;
        b_row4  = '0;
        b_row4[0][3:0] = 4'b1111;
        b_vert  = '0;
        b_diag  = '0;
        b_anti  = '0;
        for (int k = 0; k < 5; k++) begin
            b_vert[k + 3][7] = 1'b1;
            b_diag[k + 2][k + 2] = 1'b1;
            b_anti[k][7 - k] = 1'b1;
        end

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.board = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Empty board: full 256-candidate sweep, busy throughout.
        issue(b_empty, 1'b0, 0, 0, 0, 256, 64'd0);
        chk("empty_busy_first", 64'(bus.busy), 64'd1);
        repeat (255) @(negedge clk);
        chk("empty_busy_last", 64'(bus.busy), 64'd1);
        chk("empty_done_early", 64'(bus.done), 64'd0);
        wait_done("empty");
        repeat (10) @(negedge clk);

        issue(b_row, 1'b1, 0, 0, 0, 1, 64'h0000_0000_0000_001f);
        wait_done("row0");

        issue(b_vert, 1'b1, 3, 7, 1, 96, 64'h8080_8080_8000_0000);
        wait_done("vert");

        // Start pulses during the scan must not queue another scan.
        issue(b_diag, 1'b1, 2, 2, 2, 147, 64'h0040_2010_0804_0000);
        for (int p = 0; p < 3; p++) begin
            repeat (9) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done("diag");

        issue(b_anti, 1'b1, 0, 7, 3, 200, 64'h0000_0008_1020_4080);
        wait_done("anti");

        issue(b_row4, 1'b0, 0, 0, 0, 256, 64'd0);
        wait_done("row4");

        // Board changes to a winner mid-scan; the snapshot must hide it.
        issue(b_row4, 1'b0, 0, 0, 0, 256, 64'd0);
        repeat (10) @(negedge clk);
        bus.board = b_vert;
        wait_done("flip");
        bus.board = '0;

        // Reset 50 cycles into a scan: everything clears, no done follows.
        @(negedge clk);
        bus.board = b_anti;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (49) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        issue(b_row, 1'b1, 0, 0, 0, 1, 64'h0000_0000_0000_001f);
        wait_done("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
